viterbi_dec_arbiter: RTL and testbench

Two-requester arbiter and transaction sequencer in front of the Viterbi decoder `system_top` (TBL=15). It accepts 16-bit encoded words from two independent sources using valid/ready. It issues one word at a time to the decoder under stop-and-wait rules, collects the decoded byte, and returns it tagged with the requester ID. A bounded timeout guarantees forward progress if the decoder never answers.

---
 rtl/viterbi_dec_arbiter_if.sv | 33 +++
 rtl/viterbi_dec_arbiter.sv | 119 +++++++++++
 tb/tb_viterbi_dec_arbiter.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/viterbi_dec_arbiter_if.sv
// Requester, decoder-side and response signals of the Viterbi decoder front-end arbiter.
// slave is the arbiter's view; master is the view of whatever drives it.
interface viterbi_dec_arbiter_if;
    logic        req0_valid_i;
    logic [15:0] req0_data_i;
    logic        req0_ready_o;
    logic        req1_valid_i;
    logic [15:0] req1_data_i;
    logic        req1_ready_o;
    logic        dec_dvalid_o;
    logic [15:0] dec_data_o;
    logic        dec_busy_i;
    logic        dec_valid_i;
    logic [7:0]  dec_data_i;
    logic        rsp_valid_o;
    logic        rsp_id_o;
    logic [7:0]  rsp_data_o;
    logic        rsp_timeout_o;

    modport slave (
        input  req0_valid_i, req0_data_i, req1_valid_i, req1_data_i,
        input  dec_busy_i, dec_valid_i, dec_data_i,
        output req0_ready_o, req1_ready_o, dec_dvalid_o, dec_data_o,
        output rsp_valid_o, rsp_id_o, rsp_data_o, rsp_timeout_o
    );

    modport master (
        output req0_valid_i, req0_data_i, req1_valid_i, req1_data_i,
        output dec_busy_i, dec_valid_i, dec_data_i,
        input  req0_ready_o, req1_ready_o, dec_dvalid_o, dec_data_o,
        input  rsp_valid_o, rsp_id_o, rsp_data_o, rsp_timeout_o
    );
endinterface

// File: rtl/viterbi_dec_arbiter.sv
// Round-robin two-requester stop-and-wait sequencer for the Viterbi decoder; issue 1 cycle after accept,
// response 1 cycle after the accepted decoder beat or after TIMEOUT WAIT cycles. Ready only in IDLE with decoder not busy; responses never stall.
module viterbi_dec_arbiter #(
    parameter int TIMEOUT = 2000,
    parameter int DROP    = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    viterbi_dec_arbiter_if.slave  bus
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int DW = (DROP > 0) ? $clog2(DROP + 1) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
    localparam logic [DW-1:0] DMAX = DW'(DROP);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

    state_t         state_q;
    logic           last_q;
    logic           id_q;
    logic [TW-1:0]  timer_q;
    logic [DW-1:0]  drop_q;
    logic           dec_dvalid_q;
    logic [15:0]    dec_data_q;
    logic           rsp_valid_q;
    logic           rsp_id_q;
    logic [7:0]     rsp_data_q;
    logic           rsp_timeout_q;

    logic grant;
    logic rdy0;
    logic rdy1;
    logic beat_drop;
    logic beat_take;

    // On a tie the requester that did not win last time is served.
    always_comb begin
        grant = bus.req1_valid_i;
        if (bus.req0_valid_i && bus.req1_valid_i) begin
            grant = ~last_q;
        end
    end

    assign rdy0 = (state_q == IDLE) && !bus.dec_busy_i && !grant && bus.req0_valid_i;
    assign rdy1 = (state_q == IDLE) && !bus.dec_busy_i &&  grant && bus.req1_valid_i;

    assign beat_drop = bus.dec_valid_i && (drop_q < DMAX);
    assign beat_take = bus.dec_valid_i && !(drop_q < DMAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            last_q        <= 1'b1;
            id_q          <= 1'b0;
            timer_q       <= '0;
            drop_q        <= '0;
            dec_dvalid_q  <= 1'b0;
            dec_data_q    <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= 1'b0;
            rsp_data_q    <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rdy0 || rdy1) begin
                        id_q         <= grant;
                        last_q       <= grant;
                        dec_dvalid_q <= 1'b1;
                        dec_data_q   <= grant ? bus.req1_data_i : bus.req0_data_i;
                        state_q      <= ISSUE;
                    end
                end
                ISSUE: begin
                    dec_dvalid_q <= 1'b0;
                    dec_data_q   <= '0;
                    timer_q      <= '0;
                    drop_q       <= '0;
                    state_q      <= WAIT;
                end
                WAIT: begin
                    if (beat_drop) begin
                        drop_q <= drop_q + 1'b1;
                    end
                    // A data beat on the last timer cycle still counts as an answer.
                    if (beat_take) begin
                        rsp_valid_q   <= 1'b1;
                        rsp_id_q      <= id_q;
                        rsp_data_q    <= bus.dec_data_i;
                        rsp_timeout_q <= 1'b0;
                        state_q       <= RESPOND;
                    end else if (timer_q == TMAX) begin
                        rsp_valid_q   <= 1'b1;
                        rsp_id_q      <= id_q;
                        rsp_data_q    <= '0;
                        rsp_timeout_q <= 1'b1;
                        state_q       <= RESPOND;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                RESPOND: begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req0_ready_o  = rdy0;
    assign bus.req1_ready_o  = rdy1;
    assign bus.dec_dvalid_o  = dec_dvalid_q;
    assign bus.dec_data_o    = dec_data_q;
    assign bus.rsp_valid_o   = rsp_valid_q;
    assign bus.rsp_id_o      = rsp_id_q;
    assign bus.rsp_data_o    = rsp_data_q;
    assign bus.rsp_timeout_o = rsp_timeout_q;
endmodule

// File: tb/tb_viterbi_dec_arbiter.sv
// Bench for viterbi_dec_arbiter with TIMEOUT=20, DROP=1: every transaction has one flush beat
// followed by the real byte, timing predicted from the handshake rules.
module tb_viterbi_dec_arbiter;
    localparam int TO   = 20;
    localparam int DROP = 1;

    logic clk = 1'b0;
    logic rst_n;

    viterbi_dec_arbiter_if bus ();

    viterbi_dec_arbiter #(.TIMEOUT(TO), .DROP(DROP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int fails  = 0;
    int m_last = 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_dvalid"}, bus.dec_dvalid_o, 0);
        chk({tag, "_ddata"},  bus.dec_data_o, 0);
        chk({tag, "_rvalid"}, bus.rsp_valid_o, 0);
        chk({tag, "_rid"},    bus.rsp_id_o, 0);
        chk({tag, "_rdata"},  bus.rsp_data_o, 0);
        chk({tag, "_rto"},    bus.rsp_timeout_o, 0);
    endtask

    // Entered and left at posedge+1 of an IDLE cycle. lat >= 2: flush beat in the first WAIT
    // cycle, data beat lat cycles after the issue cycle; to=1 means the decoder never answers.
    task automatic do_txn(input bit v0, input bit v1, input logic [15:0] w0, input logic [15:0] w1,
                          input int busy, input int lat, input bit to, input logic [7:0] rb);
        int          g;
        int          resp_at;
        logic [15:0] w;
        g       = (v0 && v1) ? 1 - m_last : (v1 ? 1 : 0);
        w       = (g == 1) ? w1 : w0;
        resp_at = to ? TO + 1 : lat + 1;
        bus.req0_valid_i = v0;
        bus.req0_data_i  = w0;
        bus.req1_valid_i = v1;
        bus.req1_data_i  = w1;
        for (int i = 0; i < busy; i++) begin
            bus.dec_busy_i = 1'b1;
            #1;
            chk("busy_rdy0", bus.req0_ready_o, 0);
            chk("busy_rdy1", bus.req1_ready_o, 0);
            tick();
        end
        bus.dec_busy_i = 1'b0;
        #1;
        chk("grant_rdy0", bus.req0_ready_o, (g == 0));
        chk("grant_rdy1", bus.req1_ready_o, (g == 1));
        m_last = g;
        tick();
        chk("issue_dvalid", bus.dec_dvalid_o, 1);
        chk("issue_data",   bus.dec_data_o, w);
        chk("issue_rsp",    bus.rsp_valid_o, 0);
        if (g == 0) bus.req0_valid_i = 1'b0;
        else        bus.req1_valid_i = 1'b0;
        bus.dec_valid_i = 1'b1;
        bus.dec_data_i  = 8'hEE;
        for (int k = 1; k < resp_at; k++) begin
            tick();
            chk("wait_dvalid", bus.dec_dvalid_o, 0);
            chk("wait_ddata",  bus.dec_data_o, 0);
            chk("wait_rsp",    bus.rsp_valid_o, 0);
            bus.dec_valid_i = (k == 1) || (!to && k == lat);
            bus.dec_data_i  = (!to && k == lat) ? rb : 8'h00;
        end
        tick();
        chk("rsp_valid",   bus.rsp_valid_o, 1);
        chk("rsp_id",      bus.rsp_id_o, g);
        chk("rsp_data",    bus.rsp_data_o, to ? 8'h00 : rb);
        chk("rsp_timeout", bus.rsp_timeout_o, to);
        chk("rsp_rdy0",    bus.req0_ready_o, 0);
        chk("rsp_rdy1",    bus.req1_ready_o, 0);
        bus.dec_valid_i = 1'b1;
        bus.dec_data_i  = 8'h5A;
        tick();
        bus.dec_valid_i  = 1'b0;
        bus.req0_valid_i = 1'b0;
        bus.req1_valid_i = 1'b0;
        chk("rsp_one_cycle", bus.rsp_valid_o, 0);
    endtask

    initial begin
        bit          v0;
        bit          v1;
        int          lat;
        bit          to;
        rst_n            = 1'b1;
        bus.req0_valid_i = 1'b0;
        bus.req0_data_i  = '0;
        bus.req1_valid_i = 1'b0;
        bus.req1_data_i  = '0;
        bus.dec_busy_i   = 1'b0;
        bus.dec_valid_i  = 1'b0;
        bus.dec_data_i   = '0;
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("reset");
        chk("reset_rdy0", bus.req0_ready_o, 0);
        chk("reset_rdy1", bus.req1_ready_o, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Contention: both requesters always pending, grants must alternate from 0.
        for (int i = 0; i < 8; i++) begin
            do_txn(1'b1, 1'b1, 16'($urandom), 16'($urandom), 0, $urandom_range(2, 10), 1'b0, 8'($urandom));
        end

        // Single request, answer 12 cycles after dvalid.
        do_txn(1'b1, 1'b0, 16'hE217, 16'h0000, 0, 12, 1'b0, 8'h35);

        // Busy gating for 50 cycles on requester 1.
        do_txn(1'b0, 1'b1, 16'h0000, 16'hBEEF, 50, 4, 1'b0, 8'h77);

        // Timeout, then normal service; then data beat on the final timer cycle.
        do_txn(1'b1, 1'b0, 16'h1357, 16'h0000, 0, 2, 1'b1, 8'hFF);
        do_txn(1'b0, 1'b1, 16'h0000, 16'h2468, 0, 3, 1'b0, 8'h42);
        do_txn(1'b1, 1'b0, 16'hC0DE, 16'h0000, 0, TO, 1'b0, 8'h99);

        // Flush drop and stray decoder output in IDLE.
        do_txn(1'b1, 1'b0, 16'h0F0F, 16'h0000, 0, 5, 1'b0, 8'hA5);
        bus.dec_valid_i = 1'b1;
        bus.dec_data_i  = 8'h11;
        repeat (2) tick();
        bus.dec_valid_i = 1'b0;
        repeat (3) begin
            tick();
            chk("stray_rsp",    bus.rsp_valid_o, 0);
            chk("stray_dvalid", bus.dec_dvalid_o, 0);
        end

        // Reset in the middle of WAIT.
        bus.req0_valid_i = 1'b1;
        bus.req0_data_i  = 16'h1234;
        #1;
        chk("mid_rdy0", bus.req0_ready_o, 1);
        tick();
        bus.req0_valid_i = 1'b0;
        chk("mid_issue", bus.dec_dvalid_o, 1);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        repeat (3) begin
            tick();
            chk("midrst_norsp", bus.rsp_valid_o, 0);
        end
        rst_n  = 1'b1;
        m_last = 1;
        tick();
        do_txn(1'b1, 1'b1, 16'hAAAA, 16'h5555, 0, 6, 1'b0, 8'h3C);

        // Randomised traffic.
        for (int i = 0; i < 40; i++) begin
            v0  = 1'($urandom_range(0, 1));
            v1  = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
            to  = ($urandom_range(0, 5) == 0);
            lat = ($urandom_range(0, 7) == 0) ? TO : $urandom_range(2, TO);
            do_txn(v0, v1, 16'($urandom), 16'($urandom), $urandom_range(0, 3), lat, to, 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
